// File: rtl/mem_arbiter.sv
// mem_arbiter
// Three-port memory responder. The CPU (read/write), SPART (write-only) and
// audio (read-only) requesters share one word array. One transaction is in
// flight at a time. Each transaction takes a fixed ACC_LAT cycles in SERVE and
// ends with a one-cycle completion pulse on the owning port.
//
// Handshake: every request is a level. It is sampled only while the arbiter is
// IDLE. The granted requester's address, write enable and write data are
// captured at the grant edge, so later changes have no effect. Completion is a
// single-cycle rdy/ack pulse, and the arbiter is IDLE (mem_busy = 00) in that
// same cycle. A requester that still holds its request during its pulse cycle
// is arbitrated again at that cycle's closing edge.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_rdy     CPU port
//   spart_req/addr/wdata  -> spart_ack              SPART write port
//   mem_op/data_addr      -> data_in, data_rdy      audio read port
//   mem_busy                           owner code: 00 idle, 01 CPU, 10 SPART,
//                                      11 audio (also exposes the FSM state)
module mem_arbiter #(
   parameter int DEPTH   = 1024,
   parameter int ACC_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rdy,
   input  logic        spart_req,
   input  logic [31:0] spart_addr,
   input  logic [31:0] spart_wdata,
   output logic        spart_ack,
   input  logic        mem_op,
   input  logic [31:0] data_addr,
   output logic [31:0] data_in,
   output logic        data_rdy,
   output logic [1:0]  mem_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_CPU   = 2'b01;
   localparam logic [1:0] OWN_SPART = 2'b10;
   localparam logic [1:0] OWN_AUDIO = 2'b11;

   typedef enum logic {IDLE, SERVE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;
   logic [31:0]   data_in_q, data_in_d;
   logic          cpu_rdy_q, cpu_rdy_d;
   logic          spart_ack_q, spart_ack_d;
   logic          data_rdy_q, data_rdy_d;
   logic          last_audio_q, last_audio_d;
   logic          mem_wr;

   logic [31:0]   mem [DEPTH];

   // Only the word-index field of each address is meaningful.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:AW+5], cpu_addr[4:0],
                               spart_addr[31:AW+5], spart_addr[4:0],
                               data_addr[31:AW+5], data_addr[4:0]};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      data_in_d    = data_in_q;
      cpu_rdy_d    = 1'b0;
      spart_ack_d  = 1'b0;
      data_rdy_d   = 1'b0;
      last_audio_d = last_audio_q;
      mem_wr       = 1'b0;

      case (state_q)
         IDLE: begin
            owner_d = OWN_NONE;
            if (cpu_req) begin
               owner_d = OWN_CPU;
               addr_d  = cpu_addr[AW+4:5];
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
            // SPART normally ranks below audio, but it jumps ahead once an
            // audio transfer has just completed so a held mem_op cannot
            // starve it.
            end else if (spart_req && (last_audio_q || !mem_op)) begin
               owner_d = OWN_SPART;
               addr_d  = spart_addr[AW+4:5];
               we_d    = 1'b1;
               wdata_d = spart_wdata;
            end else if (mem_op) begin
               owner_d = OWN_AUDIO;
               addr_d  = data_addr[AW+4:5];
               we_d    = 1'b0;
            end
            if (cpu_req || spart_req || mem_op) begin
               state_d = SERVE;
               cnt_d   = CW'(ACC_LAT - 1);
            end
         end
         SERVE: begin
            if (cnt_q == '0) begin
               state_d      = IDLE;
               owner_d      = OWN_NONE;
               last_audio_d = (owner_q == OWN_AUDIO);
               mem_wr       = we_q;
               case (owner_q)
                  OWN_CPU: begin
                     cpu_rdy_d = 1'b1;
                     if (!we_q) cpu_rdata_d = mem[addr_q];
                  end
                  OWN_SPART: spart_ack_d = 1'b1;
                  OWN_AUDIO: begin
                     data_rdy_d = 1'b1;
                     data_in_d  = mem[addr_q];
                  end
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_NONE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         data_in_q    <= '0;
         cpu_rdy_q    <= 1'b0;
         spart_ack_q  <= 1'b0;
         data_rdy_q   <= 1'b0;
         last_audio_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         data_in_q    <= data_in_d;
         cpu_rdy_q    <= cpu_rdy_d;
         spart_ack_q  <= spart_ack_d;
         data_rdy_q   <= data_rdy_d;
         last_audio_q <= last_audio_d;
      end
   end

   // The array is not reset. mem_wr derives from state_q, which reset forces
   // to IDLE, so an aborted transaction never writes.
   always_ff @(posedge clk) begin
      if (mem_wr) mem[addr_q] <= wdata_q;
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_rdy   = cpu_rdy_q;
   assign spart_ack = spart_ack_q;
   assign data_in   = data_in_q;
   assign data_rdy  = data_rdy_q;
   assign mem_busy  = owner_q;

endmodule
